// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush/bubble controller with a fixed-latency SRAM wait-state FSM
// and saturating stall/flush statistics counters.
module pipeline_stall_controller #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branchTaken,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             clrStats,
    output logic             freezePC,
    output logic             freezeIFID,
    output logic             flushIFID,
    output logic             flushIDEX,
    output logic             freezeAll,
    output logic             memStall,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam int unsigned      LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = (MEM_LAT > 0) ? LAT_W'(MEM_LAT - 1) : '0;
    localparam logic             MEM_EN   = (MEM_LAT > 0);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_nxt;
    logic             w_mem_req;
    logic             w_mem_act;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;

    assign w_mem_req = memRead | memWrite;
    assign w_mem_act = ((r_state == S_RUN) && w_mem_req && MEM_EN) || (r_state == S_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (w_mem_req && MEM_EN) begin
                    w_cnt_nxt   = LAT_LOAD;
                    w_state_nxt = (MEM_LAT > 1) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - LAT_W'(1);
                if (r_cnt == LAT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            // The accessing instruction leaves MEM here, so a new request is not taken.
            S_DONE:  w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        freezePC   = 1'b0;
        freezeIFID = 1'b0;
        flushIFID  = 1'b0;
        flushIDEX  = 1'b0;
        freezeAll  = 1'b0;
        memStall   = 1'b0;
        if (!rst) begin
            memStall = (r_state == S_WAIT);
            if (w_mem_act) begin
                freezeAll  = 1'b1;
                freezePC   = 1'b1;
                freezeIFID = 1'b1;
            end else if (branchTaken) begin
                flushIFID = 1'b1;
                flushIDEX = 1'b1;
            end else if (hazard) begin
                freezePC   = 1'b1;
                freezeIFID = 1'b1;
                flushIDEX  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clrStats) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (freezePC && (r_stall != {CNT_W{1'b1}})) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            if (flushIFID && (r_flush != {CNT_W{1'b1}})) begin
                r_flush <= r_flush + CNT_W'(1);
            end
        end
    end

    assign stallCycles = r_stall;
    assign flushCount  = r_flush;

endmodule
